// File: rtl/n_bit_arbiter_encoder_if.sv
// Request/grant bundle shared between the arbiter and its requesters/consumer.
// The arbiter side drives the registered offer; the far side drives requests
// and the accept handshake.
interface n_bit_arbiter_encoder_if #(
   parameter int WIDTH = 4
);
   localparam int IDX_W = $clog2(WIDTH);

   logic [WIDTH-1:0] in;
   logic             lock;
   logic             ready;
   logic [IDX_W-1:0] out;
   logic [WIDTH-1:0] grant;
   logic             valid;
   logic             locked;

   modport master (
      input  in, lock, ready,
      output out, grant, valid, locked
   );

   modport slave (
      output in, lock, ready,
      input  out, grant, valid, locked
   );
endinterface

// File: rtl/n_bit_arbiter_encoder.sv
// Registered priority encoder / arbiter with a valid-ready offer.
// MODE 0 picks the highest set request; MODE 1 scans round-robin from a
// pointer that moves just past the last accepted index. An accepted grant
// may be re-offered as a locked burst if the requester asks for it.
module n_bit_arbiter_encoder #(
   parameter  int WIDTH = 4,
   parameter  int MODE  = 0,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input logic clk,
   input logic rst,
   n_bit_arbiter_encoder_if.master bus
);

   typedef enum logic [1:0] {IDLE, OFFER, LOCKED} state_t;

   state_t           stateReg, stateNext;
   logic [IDX_W-1:0] outReg, outNext;
   logic [IDX_W-1:0] ptrReg, ptrNext, ptrAfter;
   logic [WIDTH-1:0] grantReg, grantNext;
   logic             lockedReg, lockedNext;
   logic             accept;
   logic             anyReq;

   // Winner selection; the round-robin scan runs backwards so that the
   // candidate closest to the pointer is the last (and therefore winning) write.
   function automatic logic [IDX_W-1:0] win(input logic [WIDTH-1:0] req,
                                            input logic [IDX_W-1:0] p);
      logic [IDX_W-1:0] w;
      int               j;
      w = '0;
      if (MODE == 0) begin
         for (int i = 0; i < WIDTH; i++)
            if (req[i]) w = IDX_W'(i);
      end else begin
         for (int k = WIDTH - 1; k >= 0; k--) begin
            j = int'(p) + k;
            if (j >= WIDTH) j = j - WIDTH;
            if (req[j]) w = IDX_W'(j);
         end
      end
      return w;
   endfunction

   assign accept = (stateReg != IDLE) && bus.ready;
   assign anyReq = |bus.in;

   // Pointer value that takes effect on this accept; wraps explicitly so a
   // non-power-of-two WIDTH never lands on an unused index.
   always_comb begin
      ptrAfter = ptrReg;
      if (MODE == 1 && accept)
         ptrAfter = (outReg == IDX_W'(WIDTH - 1)) ? '0 : outReg + IDX_W'(1);
   end

   // Next-state and next-offer logic; an offer is frozen until it is accepted.
   always_comb begin
      stateNext  = stateReg;
      outNext    = outReg;
      lockedNext = lockedReg;
      ptrNext    = ptrReg;
      grantNext  = '0;
      case (stateReg)
         IDLE: begin
            lockedNext = 1'b0;
            if (anyReq) begin
               outNext   = win(bus.in, ptrReg);
               stateNext = OFFER;
            end
         end
         default: begin
            if (accept) begin
               ptrNext = ptrAfter;
               if (bus.lock && bus.in[outReg]) begin
                  stateNext  = LOCKED;
                  lockedNext = 1'b1;
               end else if (anyReq) begin
                  outNext    = win(bus.in, ptrAfter);
                  stateNext  = OFFER;
                  lockedNext = 1'b0;
               end else begin
                  stateNext  = IDLE;
                  lockedNext = 1'b0;
               end
            end
         end
      endcase
      if (stateNext != IDLE)
         grantNext = {{(WIDTH-1){1'b0}}, 1'b1} << outNext;
   end

   // State and offer registers; reset clears everything, including a pending offer.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg  <= IDLE;
         outReg    <= '0;
         ptrReg    <= '0;
         grantReg  <= '0;
         lockedReg <= 1'b0;
      end else begin
         stateReg  <= stateNext;
         outReg    <= outNext;
         ptrReg    <= ptrNext;
         grantReg  <= grantNext;
         lockedReg <= lockedNext;
      end
   end

   assign bus.out    = outReg;
   assign bus.grant  = grantReg;
   assign bus.valid  = (stateReg != IDLE);
   assign bus.locked = lockedReg;

endmodule

// File: tb/tb_n_bit_arbiter_encoder.sv
// Bench for n_bit_arbiter_encoder: three instances (W4 fixed, W4 round-robin,
// W5 round-robin) checked every cycle against an integer-level model, plus
// hand-computed literal expectations for the directed scenarios.
module tb_n_bit_arbiter_encoder;

   logic clk = 1'b0;
   logic rst;
   int   checks  = 0;
   int   errors  = 0;
   bit   started = 1'b0;

   n_bit_arbiter_encoder_if #(.WIDTH(4)) bus0 ();
   n_bit_arbiter_encoder_if #(.WIDTH(4)) bus1 ();
   n_bit_arbiter_encoder_if #(.WIDTH(5)) bus2 ();

   n_bit_arbiter_encoder #(.WIDTH(4), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
   n_bit_arbiter_encoder #(.WIDTH(4), .MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.master));
   n_bit_arbiter_encoder #(.WIDTH(5), .MODE(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

   // Free-running clock.
   always #5 clk = ~clk;

   // Reference model state, one slot per instance.
   int wOf[3] = '{4, 4, 5};
   int mOf[3] = '{0, 1, 1};
   int mValid[3];
   int mOut[3];
   int mLocked[3];
   int mPtr[3];

   function automatic int pick(int d, int req, int p);
      if (mOf[d] == 0) begin
         for (int i = wOf[d] - 1; i >= 0; i--)
            if ((req >> i) & 1) return i;
      end else begin
         for (int k = 0; k < wOf[d]; k++)
            if ((req >> ((p + k) % wOf[d])) & 1) return (p + k) % wOf[d];
      end
      return 0;
   endfunction

   task automatic modelStep(int d, int req, int lk, int rdy, int rs);
      if (rs != 0) begin
         mValid[d] = 0; mOut[d] = 0; mLocked[d] = 0; mPtr[d] = 0;
      end else if (mValid[d] == 0) begin
         mLocked[d] = 0;
         if (req != 0) begin
            mOut[d] = pick(d, req, mPtr[d]);
            mValid[d] = 1;
         end
      end else if (rdy != 0) begin
         if (mOf[d] == 1) mPtr[d] = (mOut[d] + 1) % wOf[d];
         if (lk != 0 && ((req >> mOut[d]) & 1) != 0) begin
            mLocked[d] = 1;
         end else if (req != 0) begin
            mOut[d] = pick(d, req, mPtr[d]);
            mLocked[d] = 0;
         end else begin
            mValid[d] = 0;
            mLocked[d] = 0;
         end
      end
   endtask

   // Advance the model on each rising edge using the inputs the DUTs see.
   always @(posedge clk) begin
      modelStep(0, int'(bus0.in), int'(bus0.lock), int'(bus0.ready), int'(rst));
      modelStep(1, int'(bus1.in), int'(bus1.lock), int'(bus1.ready), int'(rst));
      modelStep(2, int'(bus2.in), int'(bus2.lock), int'(bus2.ready), int'(rst));
   end

   task automatic checkDut(int d, logic v, int o, int g, logic l);
      int expG;
      expG = (mValid[d] != 0) ? (1 << mOut[d]) : 0;
      checks++;
      if (int'(v) != mValid[d]) begin
         errors++;
         $display("[TB] FAIL dut%0d valid got %0d expected %0d at %0t", d, v, mValid[d], $time);
      end
      if (mValid[d] != 0) begin
         checks++;
         if (o != mOut[d]) begin
            errors++;
            $display("[TB] FAIL dut%0d out got %0d expected %0d at %0t", d, o, mOut[d], $time);
         end
      end
      checks++;
      if (g != expG) begin
         errors++;
         $display("[TB] FAIL dut%0d grant got %0h expected %0h at %0t", d, g, expG, $time);
      end
      checks++;
      if (int'(l) != mLocked[d]) begin
         errors++;
         $display("[TB] FAIL dut%0d locked got %0d expected %0d at %0t", d, l, mLocked[d], $time);
      end
   endtask

   // Compare every instance against the model away from the active edge.
   always @(negedge clk) begin
      if (started) begin
         checkDut(0, bus0.valid, int'(bus0.out), int'(bus0.grant), bus0.locked);
         checkDut(1, bus1.valid, int'(bus1.out), int'(bus1.grant), bus1.locked);
         checkDut(2, bus2.valid, int'(bus2.out), int'(bus2.grant), bus2.locked);
      end
   end

   task automatic checkOutput(string name, int actual, int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1);
      rst = 1'b0;
   endtask

   int exp4[6] = '{0, 1, 2, 3, 0, 1};
   int exp5[6] = '{0, 1, 2, 3, 4, 0};

   // Directed scenarios.
   initial begin
      rst = 1'b1;
      bus0.in = 4'b1111; bus0.lock = 1'b0; bus0.ready = 1'b0;
      bus1.in = 4'b1111; bus1.lock = 1'b0; bus1.ready = 1'b0;
      bus2.in = 5'b11111; bus2.lock = 1'b0; bus2.ready = 1'b0;

      // Reset held two cycles with requests present.
      applyStimulus(1);
      started = 1'b1;
      applyStimulus(1);
      checkOutput("reset valid", int'(bus0.valid), 0);
      checkOutput("reset out", int'(bus0.out), 0);
      checkOutput("reset grant", int'(bus0.grant), 0);
      rst = 1'b0;
      checkOutput("post-reset bubble", int'(bus1.valid), 0);
      applyStimulus(1);
      checkOutput("first offer valid", int'(bus0.valid), 1);
      checkOutput("first offer fixed out", int'(bus0.out), 3);
      bus0.in = '0; bus1.in = '0; bus2.in = '0;
      bus0.ready = 1'b1; bus1.ready = 1'b1; bus2.ready = 1'b1;
      applyStimulus(1);
      checkOutput("drain valid", int'(bus0.valid), 0);
      bus1.ready = 1'b0; bus2.ready = 1'b0;

      // Fixed priority with back-to-back accepts.
      bus0.in = 4'b0101;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1);
         checkOutput("fixed out", int'(bus0.out), 2);
         checkOutput("fixed grant", int'(bus0.grant), 4);
      end
      bus0.in = '0;
      applyStimulus(1);
      checkOutput("fixed idle valid", int'(bus0.valid), 0);
      bus0.ready = 1'b0;

      // Round-robin rotation, WIDTH 4 and WIDTH 5.
      doReset();
      bus1.in = 4'b1111; bus1.ready = 1'b1;
      bus2.in = 5'b11111; bus2.ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1);
         checkOutput("rr4 out", int'(bus1.out), exp4[i]);
         checkOutput("rr5 out", int'(bus2.out), exp5[i]);
         checkOutput("rr5 model", mOut[2], exp5[i]);
      end
      bus1.in = '0; bus2.in = '0;
      applyStimulus(1);
      bus2.ready = 1'b0;

      // Stall: offer held while the request vector changes.
      doReset();
      bus1.in = 4'b0100; bus1.ready = 1'b0;
      applyStimulus(1);
      bus1.in = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1);
         checkOutput("stall out", int'(bus1.out), 2);
         checkOutput("stall valid", int'(bus1.valid), 1);
      end
      bus1.ready = 1'b1;
      applyStimulus(1);
      checkOutput("after stall out", int'(bus1.out), 0);
      bus1.in = '0;
      applyStimulus(1);

      // Lock burst, then release by dropping the request.
      doReset();
      bus1.in = 4'b1111; bus1.ready = 1'b1; bus1.lock = 1'b0;
      applyStimulus(2);
      checkOutput("lock pre out", int'(bus1.out), 1);
      bus1.lock = 1'b1;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1);
         checkOutput("lock out", int'(bus1.out), 1);
         checkOutput("lock flag", int'(bus1.locked), 1);
      end
      bus1.in = 4'b1101;
      applyStimulus(1);
      checkOutput("unlock out", int'(bus1.out), 2);
      checkOutput("unlock flag", int'(bus1.locked), 0);
      checkOutput("unlock model", mOut[1], 2);
      bus1.lock = 1'b0; bus1.in = '0;
      applyStimulus(1);

      // Reset in the middle of a stalled offer.
      doReset();
      bus1.in = 4'b1000; bus1.ready = 1'b0;
      applyStimulus(1);
      checkOutput("mid offer out", int'(bus1.out), 3);
      rst = 1'b1; bus1.in = 4'b1111;
      applyStimulus(1);
      checkOutput("mid reset valid", int'(bus1.valid), 0);
      rst = 1'b0;
      applyStimulus(1);
      checkOutput("restart valid", int'(bus1.valid), 1);
      checkOutput("restart out", int'(bus1.out), 0);
      applyStimulus(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
